uart_rx_gen2: RTL and testbench
===============================

UART_RX_GEN2 -- requirements
Module: uart_rx_gen2

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2604, giving clk cycles per bit period; legal range 16-4095.
REQ-002 SHALL have parameter DATA_BITS, default 8, giving data bits per frame; legal range 5-9.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, giving received-word buffer entries; power of 2, 2-16.
REQ-004 SHALL have port clk, input, 1 bit: system clock, rising-edge active.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port RX, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port rd_en, input, 1 bit: pop the FIFO head.
REQ-008 SHALL have port clr_err, input, 1 bit: clear all sticky error flags.
REQ-009 SHALL have port rx_data, output, DATA_BITS bits: FIFO head word, first-word fall-through.
REQ-010 SHALL have port rdy, output, 1 bit: FIFO non-empty.
REQ-011 SHALL have port frm_err, output, 1 bit: sticky flag, stop bit sampled low.
REQ-012 SHALL have port ovr_err, output, 1 bit: sticky flag, word dropped because FIFO full.
REQ-013 SHALL have port par_err, output, 1 bit: sticky flag, parity mismatch; tied 0 when parity is compiled out.

Function
REQ-014 SHALL pass RX through a 2-flop synchronizer preset to 1; all decisions use the synchronized value rxs.
REQ-015 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: SHALL go to START on rxs=0, loading the baud counter with CLK_DIV/2 (integer divide).
REQ-017 START: on baud count expiry, SHALL go to DATA if rxs=0; SHALL return to IDLE if rxs=1 (false start, no flag).
REQ-018 SHALL sample each subsequent bit once per CLK_DIV cycles at mid-bit; counter reloads on every sample.
REQ-019 DATA: SHALL shift in DATA_BITS samples LSB first; after the last sample SHALL go to PARITY if enabled, else STOP.
REQ-020 STOP: on sample rxs=1 SHALL push the word into the FIFO; on rxs=0 SHALL set frm_err and discard the word.
REQ-021 SHALL enter IDLE in the same cycle as the stop sample, so a start edge half a bit later is accepted back-to-back.
REQ-022 Push latency: rdy and rx_data SHALL be valid the cycle after the stop-bit sample when the FIFO was empty.
REQ-023 SHALL drop a push onto a full FIFO and set ovr_err, with contents unchanged.
REQ-024 Simultaneous push and rd_en on a full FIFO SHALL pop then push, with no overrun.
REQ-025 rd_en while empty SHALL be ignored, with pointers unchanged.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer MSB.
REQ-027 clr_err SHALL clear the flags next cycle; a simultaneous set event SHALL win over clr_err.

Reset
REQ-028 SHALL reset to: state IDLE; counters 0; FIFO empty; rdy 0; rx_data 0; all error flags 0; synchronizer flops 1.
REQ-029 Reset mid-frame SHALL abort the frame with no push and no flag; reception SHALL restart only on a new falling edge after release.

Configuration
REQ-030 SHALL implement the parity stage (PARITY state, par_err) only when macro UART_RX_PARITY_EN is defined.
REQ-031 With UART_RX_PARITY_EN: even parity bit SHALL follow the data bits; mismatch SHALL set par_err, and the word SHALL still be pushed.
REQ-032 Without UART_RX_PARITY_EN: the frame SHALL have no parity bit, the PARITY state SHALL be unreachable, and par_err SHALL be 0.

Structure
REQ-033 Package uart_pkg SHALL hold the rx_state_t enum and the default CLK_DIV/DATA_BITS/FIFO_DEPTH constants.
REQ-034 The FIFO SHALL be a sub-module uart_rx_fifo, parametrised by width and depth.

Verification (CLK_DIV=16, DATA_BITS=8, FIFO_DEPTH=4)
REQ-035 Frame 0xA5 with valid stop -> rdy=1 at stop sample +1, rx_data=0xA5; rd_en for one cycle -> rdy=0.
REQ-036 RX low for 5 cycles then high -> remains IDLE, rdy=0, no error flags.
REQ-037 Frame 0x3C with stop bit low -> frm_err=1, rdy=0; clr_err -> frm_err=0.
REQ-038 Five back-to-back frames 0x01-0x05, no reads -> ovr_err=1; successive pops SHALL return 0x01, 0x02, 0x03, 0x04.
REQ-039 FIFO full plus new frame with rd_en coincident with the push -> ovr_err=0, last pop returns the new word.
REQ-040 With UART_RX_PARITY_EN: frame 0x07 with parity bit 0 -> par_err=1, rx_data=0x07; rst_n pulse mid-frame -> all outputs 0, next frame 0x55 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and default parameters for the uart_rx_gen2 receiver.
// The optional parity stage is selected with the UART_RX_PARITY_EN macro.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int DEF_CLK_DIV    = 2604;
  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer; a push onto a full buffer is dropped
// and reported on o_ovr unless a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_ovr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  // The extra pointer MSB tells a full buffer apart from an empty one.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_ovr   = i_push && w_full && !w_pop;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_rx_gen2.sv
// UART receiver: mid-bit sampling FSM feeding a FWFT word FIFO, sticky error flags.
// Even-parity stage and par_err are present only when UART_RX_PARITY_EN is defined.
module uart_rx_gen2
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 rd_en,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 frm_err,
  output logic                 ovr_err,
  output logic                 par_err
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(CLK_DIV);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  logic [1:0]           r_sync;
  rx_state_t            r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_armed;
  logic                 r_frm_err;
  logic                 r_ovr_err;

  logic w_rxs;
  logic w_tick;
  logic w_push;
  logic w_frm_set;
  logic w_ovr_set;
  logic w_fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], RX};
    end
  end

  assign w_rxs     = r_sync[1];
  // The counter expires after exactly the number of cycles it was loaded with.
  assign w_tick    = (r_cnt == CNT_ONE);
  assign w_push    = (r_state == STOP) && w_tick && w_rxs;
  assign w_frm_set = (r_state == STOP) && w_tick && !w_rxs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_armed <= 1'b0;
    end else begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
      case (r_state)
        IDLE: begin
          // After reset the line must be seen idle before a low level counts as a start.
          if (w_rxs) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state <= START;
            r_cnt   <= CNT_HALF;
          end
        end
        START: begin
          if (w_tick) begin
            if (w_rxs) begin
              r_state <= IDLE;
            end else begin
              r_state <= DATA;
              r_cnt   <= CNT_FULL;
              r_bit   <= '0;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
            r_cnt   <= CNT_FULL;
            if (r_bit == BIT_LAST) begin
              r_bit <= '0;
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_bit <= r_bit + BIT_ONE;
            end
          end
        end
        PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (w_tick) begin
            r_state <= STOP;
            r_cnt   <= CNT_FULL;
          end
`else
          r_state <= IDLE;
`endif
        end
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (rd_en),
    .o_data  (rx_data),
    .o_empty (w_fifo_empty),
    .o_ovr   (w_ovr_set)
  );

  assign rdy = !w_fifo_empty;

  // A set event in the same cycle as clr_err keeps the flag raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frm_err <= 1'b0;
      r_ovr_err <= 1'b0;
    end else begin
      r_frm_err <= w_frm_set | (r_frm_err & ~clr_err);
      r_ovr_err <= w_ovr_set | (r_ovr_err & ~clr_err);
    end
  end

  assign frm_err = r_frm_err;
  assign ovr_err = r_ovr_err;

`ifdef UART_RX_PARITY_EN
  logic r_par_err;
  logic w_par_set;

  assign w_par_set = (r_state == PARITY) && w_tick && (w_rxs != (^r_shift));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= w_par_set | (r_par_err & ~clr_err);
    end
  end

  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_gen2.sv
// Directed bench for uart_rx_gen2 at CLK_DIV=16, DATA_BITS=8, FIFO_DEPTH=4.
// Parity scenarios run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_gen2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RX = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;
  logic       par_err;

  int n_cmp = 0;
  int n_bad = 0;
  int first_rdy;

  uart_rx_gen2 #(
    .CLK_DIV    (16),
    .DATA_BITS  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .rd_en   (rd_en),
    .clr_err (clr_err),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr_err (ovr_err),
    .par_err (par_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      RX = 1'b1;
      rd_en = 1'b0;
      clr_err = 1'b0;
    end
  endtask

  // Drives one frame, one bit per 16 cycles; records the first cycle rdy is seen high.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par,
                            input int pop_at, input int abort_at);
    int nbits;
    int b;
    logic bitv;
`ifdef UART_RX_PARITY_EN
    nbits = 11;
`else
    nbits = 10;
`endif
    first_rdy = -1;
    for (int c = 0; c < nbits * 16; c++) begin
      @(posedge clk); #1;
      if (first_rdy < 0 && rdy === 1'b1) first_rdy = c;
      if (c == abort_at) begin
        rst_n = 1'b0;
        RX = 1'b1;
        rd_en = 1'b0;
        break;
      end
      b = c / 16;
      if (b == 0) bitv = 1'b0;
      else if (b <= 8) bitv = d[b-1];
      else if (b == nbits - 1) bitv = stop_bit;
      else bitv = (^d) ^ bad_par;
      RX = bitv;
      rd_en = (c == pop_at);
    end
    rd_en = 1'b0;
    $display("frame %02h stop=%0b bad_par=%0b first_rdy=%0d", d, stop_bit, bad_par, first_rdy);
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    check(tag, 16'(rx_data), 16'(exp));
    @(posedge clk); #1;
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", 16'(rdy), 16'h0);
    check("rst_rx_data", 16'(rx_data), 16'h0);
    check("rst_flags", 16'({frm_err, ovr_err, par_err}), 16'h0);
    rst_n = 1'b1;
    idle(10);

    // Single good frame: rdy rises exactly one cycle after the stop sample.
    send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
    check("a5_rdy_cycle", 16'(first_rdy), 16'd155);
    idle(4);
    check("a5_rdy", 16'(rdy), 16'h1);
    pop("a5_data", 8'hA5);
    check("a5_rdy_after_pop", 16'(rdy), 16'h0);

    // Pop on an empty buffer must be ignored.
    @(posedge clk); #1; rd_en = 1'b1;
    @(posedge clk); #1; rd_en = 1'b0;
    check("empty_pop_rdy", 16'(rdy), 16'h0);

    // Glitch shorter than half a bit: false start, no flags.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; RX = 1'b0;
    end
    idle(40);
    check("glitch_rdy", 16'(rdy), 16'h0);
    check("glitch_flags", 16'({frm_err, ovr_err, par_err}), 16'h0);

    // Stop bit low: framing error, word discarded.
    send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
    idle(40);
    check("frm_err_set", 16'(frm_err), 16'h1);
    check("frm_rdy", 16'(rdy), 16'h0);
    check("frm_ovr", 16'(ovr_err), 16'h0);
    @(posedge clk); #1; clr_err = 1'b1;
    @(posedge clk); #1; clr_err = 1'b0;
    check("frm_err_clr", 16'(frm_err), 16'h0);

    // Five back-to-back frames into a 4-deep buffer: fifth overruns.
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 1'b0, -1, -1);
    idle(10);
    check("ovr_err_set", 16'(ovr_err), 16'h1);
    pop("ovr_pop0", 8'h01);
    pop("ovr_pop1", 8'h02);
    pop("ovr_pop2", 8'h03);
    pop("ovr_pop3", 8'h04);
    check("ovr_empty", 16'(rdy), 16'h0);
    @(posedge clk); #1; clr_err = 1'b1;
    @(posedge clk); #1; clr_err = 1'b0;
    check("ovr_err_clr", 16'(ovr_err), 16'h0);

    // Full buffer with a pop coincident with the push: no overrun.
    for (int k = 0; k < 4; k++) send_frame(8'h11 + 8'(k), 1'b1, 1'b0, -1, -1);
    check("full_head", 16'(rx_data), 16'h11);
    send_frame(8'h99, 1'b1, 1'b0, 154, -1);
    idle(10);
    check("coinc_ovr", 16'(ovr_err), 16'h0);
    pop("coinc_pop0", 8'h12);
    pop("coinc_pop1", 8'h13);
    pop("coinc_pop2", 8'h14);
    pop("coinc_pop3", 8'h99);
    check("coinc_empty", 16'(rdy), 16'h0);
    check("par_err_idle", 16'(par_err), 16'h0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so a parity bit of 0 is a mismatch; word still stored.
    send_frame(8'h07, 1'b1, 1'b1, -1, -1);
    idle(10);
    check("par_err_set", 16'(par_err), 16'h1);
    check("par_data", 16'(rx_data), 16'h07);
    check("par_rdy", 16'(rdy), 16'h1);

    send_frame(8'h55, 1'b1, 1'b0, -1, 60);
    #1;
    check("midrst_outputs", 16'({rdy, frm_err, ovr_err, par_err}), 16'h0);
    check("midrst_data", 16'(rx_data), 16'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(20);
    send_frame(8'h55, 1'b1, 1'b0, -1, -1);
    idle(10);
    check("post_rst_data", 16'(rx_data), 16'h55);
    check("post_rst_flags", 16'({frm_err, ovr_err, par_err}), 16'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
